// File: rtl/bf_pass_sequencer.sv
// Bellman-Ford relaxation pass sequencer.
// Steps the datapath through 8-cycle passes (two phases of four compare/exchange steps),
// checks a sticky relax flag between passes, and reports completion and convergence.
// Optional feature: define BF_EARLY_EXIT_EN to stop as soon as a pass produces no relaxation.
module bf_pass_sequencer #(
  parameter int unsigned MAX_PASS = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic       relax_in,
  output logic       phase_counter,
  output logic [1:0] step_counter,
  output logic       dp_en,
  output logic       busy,
  output logic       done,
  output logic       converged,
  output logic [5:0] pass_count
);

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  localparam logic [5:0] MaxPass = 6'(MAX_PASS);

  state_e     state_q;
  logic       relax_q;
  logic [5:0] pass_next;
  logic       exit_now;

  assign pass_next = pass_count + 6'd1;

  // >= rather than == keeps pass_count bounded even if the limit were somehow overshot.
`ifdef BF_EARLY_EXIT_EN
  assign exit_now = (pass_next >= MaxPass) || !relax_q;
`else
  assign exit_now = (pass_next >= MaxPass);
`endif

  // Capture enable follows the registered RUN state, gated off immediately while held.
  assign dp_en = (state_q == StRun) && !hold;

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      relax_q       <= 1'b0;
      phase_counter <= 1'b0;
      step_counter  <= 2'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      converged     <= 1'b0;
      pass_count    <= 6'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q       <= StRun;
            busy          <= 1'b1;
            phase_counter <= 1'b0;
            step_counter  <= 2'd0;
            pass_count    <= 6'd0;
            relax_q       <= 1'b0;
          end
        end
        StRun: begin
          if (!hold) begin
            relax_q <= relax_q | relax_in;
            if (phase_counter && (step_counter == 2'd3)) begin
              state_q       <= StCheck;
              phase_counter <= 1'b0;
              step_counter  <= 2'd0;
            end else begin
              step_counter <= step_counter + 2'd1;
              if (step_counter == 2'd3) begin
                phase_counter <= ~phase_counter;
              end
            end
          end
        end
        StCheck: begin
          pass_count <= pass_next;
          if (exit_now) begin
            state_q   <= StDone;
            done      <= 1'b1;
            converged <= ~relax_q;
          end else begin
            state_q <= StRun;
            relax_q <= 1'b0;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          busy      <= 1'b0;
          done      <= 1'b0;
          converged <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
